// File: rtl/vga_videoram_scanout.sv
// 640x480@60 VGA scanout of a 320x240 1bpp framebuffer read over the videoram Avalon-MM port.
// Every source pixel is doubled in both directions; the pixel rate is clk_clk/2.
module vga_videoram_scanout #(
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        invert,
    output logic [11:0] videoram_address,
    output logic        videoram_chipselect,
    output logic        videoram_clken,
    output logic        videoram_write,
    output logic [31:0] videoram_writedata,
    output logic [3:0]  videoram_byteenable,
    input  logic [31:0] videoram_readdata,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    localparam int unsigned CW = 10;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    localparam logic [CW-1:0] H_LAST      = 10'd799;
    localparam logic [CW-1:0] H_VIS       = 10'd640;
    localparam logic [CW-1:0] HS_START    = 10'd656;
    localparam logic [CW-1:0] HS_END      = 10'd751;
    localparam logic [CW-1:0] H_PREFETCH  = 10'd768;
    localparam logic [CW-1:0] H_FETCH_END = 10'd576;
    localparam logic [CW-1:0] V_LAST      = 10'd524;
    localparam logic [CW-1:0] V_VIS       = 10'd480;
    localparam logic [CW-1:0] VS_START    = 10'd490;
    localparam logic [CW-1:0] VS_END      = 10'd491;

    logic          phase;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic [DW-1:0] shreg;
    logic [DW-1:0] next_word;
    logic          inv_latched;
    logic          rd_pending;

    logic          tick_c;
    logic [CW-1:0] h_next_c;
    logic [CW-1:0] v_inc_c;
    logic          prefetch_c;
    logic          mid_fetch_c;
    logic [CW-1:0] target_v_c;
    logic [3:0]    word_c;
    logic [AW-1:0] row_c;
    logic [AW-1:0] fetch_addr_c;
    logic          fetch_c;
    logic          visible_c;
    logic          load_c;
    logic [DW-1:0] shreg_eff_c;
    logic          first_c;
    logic          inv_eff_c;
    logic          pix_c;
    logic [11:0]   colour_c;

    assign videoram_clken      = 1'b1;
    assign videoram_write      = 1'b0;
    assign videoram_writedata  = '0;
    assign videoram_byteenable = 4'hF;

    // Timing decode, fetch scheduling and pixel selection for the current tick.
    always_comb begin
        tick_c       = ~phase;
        h_next_c     = (h == H_LAST) ? '0 : h + 10'd1;
        v_inc_c      = (v == V_LAST) ? '0 : v + 10'd1;
        prefetch_c   = (h == H_PREFETCH);
        mid_fetch_c  = (h[5:0] == 6'd32) && (h < H_FETCH_END);
        target_v_c   = prefetch_c ? v_inc_c : v;
        word_c       = prefetch_c ? 4'd0 : 4'((h + 10'd32) >> 6);
        row_c        = AW'(target_v_c >> 1);
        fetch_addr_c = (row_c << 3) + (row_c << 1) + AW'(word_c);
        fetch_c      = tick_c && (prefetch_c || mid_fetch_c) && (target_v_c < V_VIS);
        visible_c    = (h < H_VIS) && (v < V_VIS);
        load_c       = (h[5:0] == 6'd0) && (h < H_VIS);
        // The word loaded on this tick is already the one being displayed.
        shreg_eff_c  = load_c ? next_word : shreg;
        first_c      = (h == '0) && (v == '0);
        inv_eff_c    = first_c ? invert : inv_latched;
        pix_c        = shreg_eff_c[DW-1] ^ inv_eff_c;
        colour_c     = '0;
        if (visible_c) begin
            colour_c = pix_c ? FG_COLOR : BG_COLOR;
        end
    end

    // Counters, RAM read port, shift register and registered video outputs.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            phase               <= 1'b0;
            h                   <= H_PREFETCH;
            v                   <= V_LAST;
            shreg               <= '0;
            next_word           <= '0;
            inv_latched         <= 1'b0;
            rd_pending          <= 1'b0;
            videoram_address    <= '0;
            videoram_chipselect <= 1'b0;
            vga_hsync           <= 1'b1;
            vga_vsync           <= 1'b1;
            vga_r               <= '0;
            vga_g               <= '0;
            vga_b               <= '0;
            frame_start         <= 1'b0;
        end else begin
            phase               <= ~phase;
            videoram_chipselect <= 1'b0;
            frame_start         <= 1'b0;
            rd_pending          <= videoram_chipselect;
            if (rd_pending) begin
                next_word <= videoram_readdata;
            end
            if (tick_c) begin
                h <= h_next_c;
                if (h == H_LAST) begin
                    v <= v_inc_c;
                end
                if (fetch_c) begin
                    videoram_chipselect <= 1'b1;
                    videoram_address    <= fetch_addr_c;
                end
                if (load_c) begin
                    shreg <= next_word;
                end else if (h[0] && (h < H_VIS)) begin
                    shreg <= shreg << 1;
                end
                if (first_c) begin
                    inv_latched <= invert;
                end
                vga_hsync   <= !((h >= HS_START) && (h <= HS_END));
                vga_vsync   <= !((v >= VS_START) && (v <= VS_END));
                vga_r       <= colour_c[11:8];
                vga_g       <= colour_c[7:4];
                vga_b       <= colour_c[3:0];
                frame_start <= first_c;
            end
        end
    end

endmodule

// File: tb/tb_vga_videoram_scanout.sv
// Directed bench for vga_videoram_scanout: reset values, sync and pixel timing, fetch
// addresses, invert latching and mid-line reset against a spec-level pixel model.
`timescale 1ns/1ps
module tb_vga_videoram_scanout;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        invert = 1'b0;
    logic [11:0] videoram_address;
    logic        videoram_chipselect;
    logic        videoram_clken;
    logic        videoram_write;
    logic [31:0] videoram_writedata;
    logic [3:0]  videoram_byteenable;
    logic [31:0] videoram_readdata = '0;
    logic        vga_hsync, vga_vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        frame_start;

    int n_cmp = 0;
    int n_fail = 0;
    int cnt = 0;
    int f0 = 0;
    int tie_bad = 0;
    int cs_wide = 0;
    logic cs_prev = 1'b0;
    int q_addr[$];
    int q_time[$];
    logic [31:0] mem [0:4095];
    logic [11:0] ref_rgb [0:2399];

    vga_videoram_scanout #(.FG_COLOR(12'hFFF), .BG_COLOR(12'h000)) dut (
        .clk_clk(clk), .reset_reset(reset), .invert(invert),
        .videoram_address(videoram_address), .videoram_chipselect(videoram_chipselect),
        .videoram_clken(videoram_clken), .videoram_write(videoram_write),
        .videoram_writedata(videoram_writedata), .videoram_byteenable(videoram_byteenable),
        .videoram_readdata(videoram_readdata),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    // On-chip RAM with one clock of read latency.
    always @(posedge clk) begin
        if (videoram_chipselect === 1'b1) videoram_readdata <= mem[videoram_address];
    end

    always @(negedge clk) begin
        if (videoram_write !== 1'b0 || videoram_byteenable !== 4'hF ||
            videoram_clken !== 1'b1 || videoram_writedata !== 32'h0) tie_bad++;
        if (videoram_chipselect === 1'b1 && cs_prev === 1'b1) cs_wide++;
        cs_prev = videoram_chipselect;
        if (videoram_chipselect === 1'b1) begin
            q_addr.push_back(int'(videoram_address));
            q_time.push_back(cnt);
        end
    end

    task automatic wait_fs(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (frame_start === 1'b1) break;
        end
        f0 = cnt;
    endtask

    task automatic do_reset();
        int lat;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        q_addr.delete();
        q_time.delete();
        reset = 1'b0;
        wait_fs(lat);
        n_cmp++;
        if (lat !== 65) begin
            n_fail++;
            $display("FAIL fs_latency: got %0d clocks, expected 65", lat);
        end
    endtask

    task automatic wait_to(input int p);
        while (cnt < f0 + 2 * p) @(negedge clk);
    endtask

    // mode 0: model only, 1: model and record reference, 2: model and reference
    task automatic scan_lines(input int first, input int nlines, input logic inv, input int mode);
        int h, v;
        logic [31:0] w;
        logic [11:0] e, got;
        logic bitv;
        for (int p = first * 800; p < (first + nlines) * 800; p++) begin
            wait_to(p);
            h = p % 800;
            v = p / 800;
            e = 12'h000;
            if (h < 640 && v < 480) begin
                w = mem[(v / 2) * 10 + h / 64];
                bitv = w[31 - (h % 64) / 2] ^ inv;
                e = bitv ? 12'hFFF : 12'h000;
            end
            got = {vga_r, vga_g, vga_b};
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL rgb v=%0d h=%0d: got %h, expected %h", v, h, got, e);
            end
            n_cmp++;
            if (vga_hsync !== ((h >= 656 && h <= 751) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL hsync v=%0d h=%0d: got %b", v, h, vga_hsync);
            end
            n_cmp++;
            if (vga_vsync !== ((v >= 490 && v <= 491) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL vsync v=%0d h=%0d: got %b", v, h, vga_vsync);
            end
            n_cmp++;
            if (frame_start !== ((p == 0) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL frame_start v=%0d h=%0d: got %b", v, h, frame_start);
            end
            if (mode == 1 && p < 2400) ref_rgb[p] = got;
            if (mode == 2 && p < 2400) begin
                n_cmp++;
                if (got !== ref_rgb[p]) begin
                    n_fail++;
                    $display("FAIL ref_frame v=%0d h=%0d: got %h, reference %h", v, h, got, ref_rgb[p]);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (vga_hsync !== 1'b1 || vga_vsync !== 1'b1 || {vga_r, vga_g, vga_b} !== 12'h000 ||
            videoram_chipselect !== 1'b0 || videoram_address !== 12'h000 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: hs=%b vs=%b rgb=%h cs=%b addr=%h fs=%b, expected 1 1 000 0 000 0",
                     tag, vga_hsync, vga_vsync, {vga_r, vga_g, vga_b}, videoram_chipselect,
                     videoram_address, frame_start);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        do_reset();
    endtask

    task automatic test_pixel_order();
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0] = 32'h8000_0001;
        do_reset();
        scan_lines(0, 3, 1'b0, 0);
    endtask

    task automatic test_address();
        int ln, k;
        do_reset();
        wait_to(3200);
        n_cmp++;
        if (q_addr.size() !== 41) begin
            n_fail++;
            $display("FAIL strobe_count: got %0d, expected 41", q_addr.size());
        end
        for (int i = 0; i < 41 && i < q_addr.size(); i++) begin
            ln = i / 10;
            k = i % 10;
            n_cmp++;
            if (q_addr[i] !== (ln / 2) * 10 + k) begin
                n_fail++;
                $display("FAIL addr[%0d]: got %0d, expected %0d", i, q_addr[i], (ln / 2) * 10 + k);
            end
            n_cmp++;
            if (q_time[i] !== f0 + 2 * (ln * 800 + 64 * k - 32)) begin
                n_fail++;
                $display("FAIL strobe_time[%0d]: got %0d, expected %0d", i, q_time[i],
                         f0 + 2 * (ln * 800 + 64 * k - 32));
            end
        end
    endtask

    task automatic test_reset_mid_line();
        int lat;
        for (int i = 0; i < 4096; i++) mem[i] = (i * 32'h9E37_79B1) ^ (i << 17) ^ 32'h8001_0001;
        do_reset();
        scan_lines(0, 3, 1'b0, 1);
        wait_to(3 * 800 + 288);
        n_cmp++;
        if (videoram_chipselect !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_read: cs got %b, expected 1", videoram_chipselect);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_line_reset");
        reset = 1'b0;
        wait_fs(lat);
        n_cmp++;
        if (lat !== 65) begin
            n_fail++;
            $display("FAIL mid_reset_fs_latency: got %0d, expected 65", lat);
        end
        scan_lines(0, 3, 1'b0, 2);
    endtask

    task automatic test_invert();
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        invert = 1'b0;
        do_reset();
        scan_lines(0, 1, 1'b0, 0);
        invert = 1'b1;
        scan_lines(1, 2, 1'b0, 0);
        do_reset();
        scan_lines(0, 2, 1'b1, 0);
        invert = 1'b0;
    endtask

    task automatic test_tied();
        n_cmp++;
        if (tie_bad !== 0) begin
            n_fail++;
            $display("FAIL tied_outputs: %0d bad samples, expected 0", tie_bad);
        end
        n_cmp++;
        if (cs_wide !== 0) begin
            n_fail++;
            $display("FAIL cs_width: %0d multi-clock strobes, expected 0", cs_wide);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        test_reset();
        test_pixel_order();
        test_address();
        test_reset_mid_line();
        test_invert();
        test_tied();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
